uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit sequencer for the 8-bit TX shift register. It accepts a byte-send request and pulses the shift register's `load` and `shift` controls at baud-rate boundaries. It frames the register's serial LSB output with a start bit and stop bit(s) onto the TX line. It sits between the host-side request logic and the shift register; the 8-bit data word goes straight to the shift register, not through this block.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  reset, asynchronous, active-high. The shift register's active-low clear is driven from `~clr` at integration.
- `tx_start`  in  1  send request; the byte on the shift register's `Data` bus must be valid in the same cycle.
- `sr_data`  in  1  shift register LSB (its `tx_data` output).
- `load`  out  1  shift register load enable.
- `shift`  out  1  shift register shift-right enable.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, START, DATA, STOP. Registers:
  - baud counter `cnt`, width $clog2(CLKS_PER_BIT);
  - bit index `bit_idx`, 3 bits;
  - stop-bit index, 1 bit;
  - `done` register.
- `bit_end` = (`cnt` == CLKS_PER_BIT-1). `cnt` increments every cycle outside IDLE, wraps to 0 on `bit_end`, and is held at 0 in IDLE.
- IDLE: `tx`=1, `busy`=0. When `tx_start`=1:
  - `load`=1 in that cycle;
  - next state is START, with `cnt`=0.
- START: `tx`=0. On `bit_end`: go to DATA with `bit_idx`=0.
- DATA: `tx`=`sr_data`. On `bit_end`:
  - if `bit_idx` < 7: `shift`=1 for that cycle and `bit_idx` increments;
  - if `bit_idx` = 7: no shift; go to STOP.
  - Bits go out LSB first. Exactly 7 shift pulses occur per frame.
- STOP: `tx`=1. On `bit_end` of the last stop bit (STOP_BITS total): go to IDLE and set `done`=1 for one cycle.
- `load` and `shift` are never high in the same cycle. `load` is asserted only in IDLE.
- `tx_start` is ignored outside IDLE; no queuing.
- `busy` = (state != IDLE).
- `tx` is decoded from the registered state and `sr_data` only. There is no combinational path from `tx_start` to `tx`.

## Timing
- `load` is combinational: (state==IDLE) & `tx_start`. The shift register captures `Data` on the same rising edge that moves the FSM to START.
- `shift` is combinational: (state==DATA) & `bit_end` & (`bit_idx` != 7). The next bit appears on `sr_data` in the cycle after the shift edge, which is the first cycle of the next bit period.
- Frame length from the accept edge to the first IDLE cycle is (9+STOP_BITS)*CLKS_PER_BIT cycles. Each bit holds `tx` for exactly CLKS_PER_BIT cycles.
- `done` is registered and high only in the first IDLE cycle after STOP. If `tx_start`=1 in that cycle, the request is accepted (back-to-back frames with no idle gap).
- Reset values while `clr`=1 and after it deasserts:
  - state IDLE, `cnt`=0, `bit_idx`=0, `done`=0;
  - `tx`=1, `busy`=0;
  - `load`=0 and `shift`=0, both gated by `~clr`.
- Reset mid-frame aborts immediately. `tx` returns high asynchronously and no `done` pulse is generated.
- The first edge after `clr` deasserts behaves as IDLE. `tx_start` held high across reset release is accepted on that edge.

## Test plan
- Reset/idle: assert `clr` for 3 cycles with `tx_start`=1 -> `tx`=1, `busy`=0, `load`=0, `shift`=0, `done`=0 throughout; after release, `load`=1 in the first cycle `tx_start` is still high.
- Single frame (CLKS_PER_BIT=4, STOP_BITS=1, Data=0xA5):
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles;
  - `busy` high for 40 cycles;
  - exactly 1 `load` and 7 `shift` pulses;
  - `done` pulse in cycle 41.
- Two stop bits (STOP_BITS=2, Data=0xFF) -> stop-high period lasts 8 cycles; frame is 44 cycles; `done` appears after the second stop bit.
- Back-to-back: 0x00 then 0x3C with `tx_start` high in the `done` cycle -> second start bit begins the next cycle; no idle-high gap; 0x3C appears LSB first as 0,0,1,1,1,1,0,0.
- Ignored request: pulse `tx_start` during DATA of a 0x55 frame -> no `load`; frame is unchanged; `done` pulses once.
- Reset mid-frame: assert `clr` during data bit 3 -> `tx`=1 and `busy`=0 in the same cycle; no `done`; a new 0x81 frame after release is transmitted correctly.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: drives load/shift of an external 8-bit TX shift register
// and frames its serial LSB with start and stop bits onto the line.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic tx_start,
  input  logic sr_data,
  output logic load,
  output logic shift,
  output logic tx,
  output logic busy,
  output logic done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic            stop_idx;
  logic            bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign busy    = (state != IDLE);

  // Both strobes are gated by clr so the shift register sees nothing during reset.
  assign load  = ~clr & (state == IDLE) & tx_start;
  assign shift = ~clr & (state == DATA) & bit_end & (bit_idx != 3'd7);

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = sr_data;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (tx_start) state <= START;
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          // The last data bit is already on sr_data, so no eighth shift.
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_idx == LAST_STOP) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (one and two stop bits) each with a shift
// register model, checked cycle by cycle against the expected serial frame.
module tb_uart_tx_ctrl;

  localparam int C = 4;

  logic       clk;
  logic       clr;
  logic       start [2];
  logic [7:0] data  [2];
  logic [7:0] sr    [2];
  logic       load  [2];
  logic       shift [2];
  logic       tx    [2];
  logic       busy  [2];
  logic       done  [2];
  logic       sr_lsb0, sr_lsb1;

  int errors = 0;
  int checks = 0;

  assign sr_lsb0 = sr[0][0];
  assign sr_lsb1 = sr[1][0];

  uart_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .clk(clk), .clr(clr), .tx_start(start[0]), .sr_data(sr_lsb0),
    .load(load[0]), .shift(shift[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .clr(clr), .tx_start(start[1]), .sr_data(sr_lsb1),
    .load(load[1]), .shift(shift[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1])
  );

  // Shift register models, cleared by ~clr (active-low clear) at integration.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr[0] <= '0;
      sr[1] <= '0;
    end else begin
      if (load[0]) sr[0] <= data[0];
      else if (shift[0]) sr[0] <= {1'b0, sr[0][7:1]};
      if (load[1]) sr[1] <= data[1];
      else if (shift[1]) sr[1] <= {1'b0, sr[1][7:1]};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level at cycle i of a frame: start bit, 8 data bits LSB first, then stop.
  function automatic logic exp_tx(input logic [7:0] d, input int i);
    int b;
    b = i / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic accept(input int u, input logic [7:0] d, input logic exp_done);
    start[u] = 1'b1;
    data[u]  = d;
    @(negedge clk);
    checks++;
    if ({load[u], shift[u]} !== 2'b10) begin
      errors++; $display("FAIL accept_strobes u=%0d load/shift=%b%b want 10", u, load[u], shift[u]);
    end
    checks++;
    if ({busy[u], tx[u], done[u]} !== {2'b01, exp_done}) begin
      errors++; $display("FAIL accept_state u=%0d busy/tx/done=%b%b%b want 01%b", u, busy[u], tx[u], done[u], exp_done);
    end
    @(posedge clk); #1;
    start[u] = 1'b0;
  endtask

  task automatic body(input int u, input logic [7:0] d, input int stops, input int poke);
    int nsh;
    nsh = 0;
    for (int i = 0; i < (9 + stops) * C; i++) begin
      if (i == poke) start[u] = 1'b1;
      @(negedge clk);
      checks++;
      if (tx[u] !== exp_tx(d, i)) begin
        errors++; $display("FAIL frame_tx u=%0d d=%h cyc=%0d got %b want %b", u, d, i, tx[u], exp_tx(d, i));
      end
      checks++;
      if ({busy[u], done[u], load[u]} !== 3'b100) begin
        errors++; $display("FAIL frame_ctrl u=%0d cyc=%0d busy/done/load=%b%b%b want 100", u, i, busy[u], done[u], load[u]);
      end
      if (shift[u] === 1'b1) nsh++;
      @(posedge clk); #1;
      start[u] = 1'b0;
    end
    checks++;
    if (nsh !== 7) begin
      errors++; $display("FAIL shift_count u=%0d got %0d want 7", u, nsh);
    end
  endtask

  task automatic done_check(input int u);
    @(negedge clk);
    checks++;
    if ({done[u], busy[u], tx[u], load[u]} !== 4'b1010) begin
      errors++; $display("FAIL done_pulse u=%0d done/busy/tx/load=%b%b%b%b want 1010", u, done[u], busy[u], tx[u], load[u]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({done[u], busy[u], tx[u]} !== 3'b001) begin
      errors++; $display("FAIL done_once u=%0d done/busy/tx=%b%b%b want 001", u, done[u], busy[u], tx[u]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    d = 8'($urandom);
    start[0] = 1'b1; start[1] = 1'b1; data[0] = d; data[1] = 8'h00;
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if ({tx[u], busy[u], load[u], shift[u], done[u]} !== 5'b10000) begin
          errors++; $display("FAIL reset_outputs u=%0d tx/busy/load/shift/done=%b%b%b%b%b want 10000", u, tx[u], busy[u], load[u], shift[u], done[u]);
        end
      end
      @(posedge clk); #1;
    end
    clr = 1'b0;
    start[1] = 1'b0;
    accept(0, d, 1'b0);
    body(0, d, 1, -1);
    done_check(0);
  endtask

  task automatic test_single_frame();
    accept(0, 8'hA5, 1'b0);
    body(0, 8'hA5, 1, -1);
    done_check(0);
  endtask

  task automatic test_two_stop();
    accept(1, 8'hFF, 1'b0);
    body(1, 8'hFF, 2, -1);
    done_check(1);
  endtask

  task automatic test_back_to_back();
    accept(0, 8'h00, 1'b0);
    body(0, 8'h00, 1, -1);
    accept(0, 8'h3C, 1'b1);
    body(0, 8'h3C, 1, -1);
    done_check(0);
  endtask

  task automatic test_ignored_request();
    accept(0, 8'h55, 1'b0);
    body(0, 8'h55, 1, 3 * C + 2);
    done_check(0);
  endtask

  task automatic test_reset_mid();
    accept(0, 8'hC3, 1'b0);
    for (int i = 0; i < 4 * C + 1; i++) begin
      @(negedge clk);
      checks++;
      if (tx[0] !== exp_tx(8'hC3, i)) begin
        errors++; $display("FAIL pre_abort_tx cyc=%0d got %b want %b", i, tx[0], exp_tx(8'hC3, i));
      end
      @(posedge clk); #1;
    end
    clr = 1'b1;
    #1;
    checks++;
    if ({tx[0], busy[0], shift[0], load[0]} !== 4'b1000) begin
      errors++; $display("FAIL abort_async tx/busy/shift/load=%b%b%b%b want 1000", tx[0], busy[0], shift[0], load[0]);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({done[0], busy[0], tx[0]} !== 3'b001) begin
        errors++; $display("FAIL abort_hold done/busy/tx=%b%b%b want 001", done[0], busy[0], tx[0]);
      end
      @(posedge clk); #1;
    end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({done[0], busy[0], tx[0]} !== 3'b001) begin
      errors++; $display("FAIL abort_no_done done/busy/tx=%b%b%b want 001", done[0], busy[0], tx[0]);
    end
    @(posedge clk); #1;
    accept(0, 8'h81, 1'b0);
    body(0, 8'h81, 1, -1);
    done_check(0);
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    int gap;
    for (int k = 0; k < 4; k++) begin
      d   = 8'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if ({busy[0], tx[0]} !== 2'b01) begin
          errors++; $display("FAIL idle_line busy/tx=%b%b want 01", busy[0], tx[0]);
        end
        @(posedge clk); #1;
      end
      accept(0, d, 1'b0);
      body(0, d, 1, -1);
      done_check(0);
    end
  endtask

  initial begin
    clr = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    data[0] = 8'h00; data[1] = 8'h00;
    test_reset();
    test_single_frame();
    test_two_stop();
    test_back_to_back();
    test_ignored_request();
    test_reset_mid();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
